nios_result_rx: RTL and testbench

- Receives calculation results from the Nios II over a new 24-bit PIO. The export is `pio_nios_to_fpga`, which carries traffic in the direction opposite to `pio_fpga_to_nios`.
- Runs a toggle/ack handshake on each word and frames a RESULT word followed by a STATUS word.
- Presents a registered signed result, its display magnitude, and flags to the calculator top level. This replaces on-FPGA arithmetic.
- Runs in the `fifty_MHz` domain, alongside the Qsys system.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/nios_result_rx_if.sv | 31 +++
 rtl/abs20.sv | 12 +
 rtl/nios_result_rx.sv | 161 ++++++++++++++++
 tb/tb_nios_result_rx.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the FPGA <-> Nios II calculator link: word layout,
// receive tags, receive FSM states and the fpga_to_nios opcodes.
package calc_pkg;

    localparam int WORD_W     = 24;
    localparam int PAYLOAD_W  = 20;
    localparam int TOGGLE_BIT = 23;
    localparam int TAG_HI     = 22;
    localparam int TAG_LO     = 20;

    // nios_to_fpga tags
    localparam logic [2:0] TAG_RESULT = 3'b001;
    localparam logic [2:0] TAG_STATUS = 3'b010;
    localparam logic [2:0] TAG_CLEAR  = 3'b111;

    // fpga_to_nios opcodes
    localparam logic [2:0] OP_OPERAND_ONE = 3'b001;
    localparam logic [2:0] OP_OPERAND_TWO = 3'b010;
    localparam logic [2:0] OP_ADD         = 3'b011;
    localparam logic [2:0] OP_SUB         = 3'b100;
    localparam logic [2:0] OP_MUL         = 3'b101;
    localparam logic [2:0] OP_DIV         = 3'b110;
    localparam logic [2:0] OP_CLEAR       = 3'b111;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_RES  = 2'b01,
        WAIT_STAT = 2'b10
    } rx_state_e;

endpackage

// File: rtl/nios_result_rx_if.sv
// PIO handshake and result bus between the Nios result receiver and the
// calculator top level.
interface nios_result_rx_if;
    import calc_pkg::*;

    logic [WORD_W-1:0]    pio_word;
    logic                 req;
    logic                 clr;
    logic                 ack_toggle;
    logic                 busy;
    logic [PAYLOAD_W-1:0] result;
    logic [PAYLOAD_W-1:0] result_mag;
    logic                 neg_out;
    logic                 div_zero;
    logic                 overflow;
    logic                 timeout;
    logic                 result_valid;

    modport master (
        output pio_word, req, clr,
        input  ack_toggle, busy, result, result_mag, neg_out,
               div_zero, overflow, timeout, result_valid
    );

    modport slave (
        input  pio_word, req, clr,
        output ack_toggle, busy, result, result_mag, neg_out,
               div_zero, overflow, timeout, result_valid
    );

endinterface

// File: rtl/abs20.sv
// Combinational two's-complement magnitude of a 20-bit value. The most
// negative value maps onto itself (no saturation).
module abs20 (
    input  logic [19:0] value,
    output logic [19:0] magnitude,
    output logic        negative
);

    assign negative  = value[19];
    assign magnitude = value[19] ? (~value + 20'd1) : value;

endmodule

// File: rtl/nios_result_rx.sv
// Receives RESULT/STATUS frames from the Nios II over a toggle/ack PIO and
// presents the registered signed result, its magnitude and status flags.
module nios_result_rx
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic            fifty_MHz,
    input  logic            reset,
    nios_result_rx_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    rx_state_e            state_r, state_s;
    logic [WORD_W-1:0]    word_r;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [PAYLOAD_W-1:0] shadow_r, shadow_s;
    logic [PAYLOAD_W-1:0] result_r, result_s, mag_r, mag_s;
    logic                 ack_r, ack_s, neg_r, neg_s, dz_r, dz_s, ov_r, ov_s;
    logic                 to_r, to_s, valid_r, valid_s, busy_r, busy_s;

    logic [2:0]           tag_s;
    logic [PAYLOAD_W-1:0] payload_s, shadow_mag_s;
    logic                 pending_s, expired_s, shadow_neg_s;

    assign tag_s     = word_r[TAG_HI:TAG_LO];
    assign payload_s = word_r[PAYLOAD_W-1:0];
    assign pending_s = word_r[TOGGLE_BIT] ^ ack_r;
    assign expired_s = (cnt_r == CNT_LAST);

    abs20 u_abs (
        .value     (shadow_r),
        .magnitude (shadow_mag_s),
        .negative  (shadow_neg_s)
    );

    // Next-state and next-output logic. Taking ack from the word's toggle
    // accepts a pending word and is a no-op when nothing is pending.
    always_comb begin
        state_s  = state_r;
        ack_s    = ack_r;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        result_s = result_r;
        mag_s    = mag_r;
        neg_s    = neg_r;
        dz_s     = dz_r;
        ov_s     = ov_r;
        to_s     = to_r;
        valid_s  = 1'b0;

        if (bus.clr) begin
            state_s  = IDLE;
            ack_s    = word_r[TOGGLE_BIT];
            cnt_s    = '0;
            result_s = '0;
            mag_s    = '0;
            neg_s    = 1'b0;
            dz_s     = 1'b0;
            ov_s     = 1'b0;
            to_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req) begin
                        state_s = WAIT_RES;
                        cnt_s   = '0;
                        to_s    = 1'b0;
                    end else begin
                        ack_s = word_r[TOGGLE_BIT];
                    end
                end
                WAIT_RES, WAIT_STAT: begin
                    if (pending_s) begin
                        ack_s = word_r[TOGGLE_BIT];
                        case (tag_s)
                            TAG_RESULT: begin
                                shadow_s = payload_s;
                                cnt_s    = '0;
                                state_s  = WAIT_STAT;
                            end
                            TAG_STATUS: begin
                                state_s = IDLE;
                                valid_s = 1'b1;
                                if (state_r == WAIT_STAT) begin
                                    result_s = shadow_r;
                                    mag_s    = shadow_mag_s;
                                    neg_s    = shadow_neg_s;
                                    dz_s     = payload_s[0];
                                    ov_s     = payload_s[1];
                                end else begin
                                    // STATUS without RESULT: protocol error
                                    to_s = 1'b0;
                                    dz_s = 1'b1;
                                    ov_s = 1'b1;
                                end
                            end
                            default: state_s = IDLE;
                        endcase
                    end else if (expired_s) begin
                        state_s = IDLE;
                        to_s    = 1'b1;
                        valid_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // State, input word and output registers.
    always_ff @(posedge fifty_MHz or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            word_r   <= '0;
            ack_r    <= 1'b0;
            cnt_r    <= '0;
            shadow_r <= '0;
            result_r <= '0;
            mag_r    <= '0;
            neg_r    <= 1'b0;
            dz_r     <= 1'b0;
            ov_r     <= 1'b0;
            to_r     <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            word_r   <= bus.pio_word;
            ack_r    <= ack_s;
            cnt_r    <= cnt_s;
            shadow_r <= shadow_s;
            result_r <= result_s;
            mag_r    <= mag_s;
            neg_r    <= neg_s;
            dz_r     <= dz_s;
            ov_r     <= ov_s;
            to_r     <= to_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.ack_toggle   = ack_r;
    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_mag   = mag_r;
    assign bus.neg_out      = neg_r;
    assign bus.div_zero     = dz_r;
    assign bus.overflow     = ov_r;
    assign bus.timeout      = to_r;
    assign bus.result_valid = valid_r;

endmodule

// File: tb/tb_nios_result_rx.sv
// Directed bench for nios_result_rx: frames, signed magnitude, flags, timeout,
// same-cycle request/word, and the abort paths.
module tb_nios_result_rx;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic tog;
    int   errors = 0;
    int   checks = 0;
    int   pulse_cnt = 0;

    nios_result_rx_if bus();

    nios_result_rx #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .fifty_MHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (bus.result_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic nios_write(input logic [2:0] tag, input logic [19:0] payload);
        tog = ~tog;
        bus.pio_word = {tog, tag, payload};
    endtask

    task automatic pulse_req();
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
    endtask

    task automatic run_frame(input logic [19:0] rp, input logic [19:0] sp);
        pulse_req();
        nios_write(TAG_RESULT, rp);
        step(2);
        nios_write(TAG_STATUS, sp);
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tog = 1'b0;
        bus.pio_word = 24'h000000;
        bus.req = 1'b0;
        bus.clr = 1'b0;
        step(3);
        checks++;
        if ({bus.ack_toggle, bus.busy, bus.result, bus.result_mag, bus.neg_out, bus.div_zero,
             bus.overflow, bus.timeout, bus.result_valid} !== 47'h0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h mag=%h busy=%b ack=%b expected all zero",
                     bus.result, bus.result_mag, bus.busy, bus.ack_toggle);
        end
        reset = 1'b1;
        step(2);
        checks++;
        if ({bus.busy, bus.result_valid, bus.ack_toggle} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy/valid/ack=%b expected 000",
                     {bus.busy, bus.result_valid, bus.ack_toggle});
        end
    endtask

    task automatic test_basic();
        pulse_req();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy);
        end
        nios_write(TAG_RESULT, 20'h00064);
        step(2);
        checks++;
        if ({bus.ack_toggle, bus.busy} !== 2'b11) begin
            errors++; $display("FAIL basic_ack_result: got ack/busy=%b expected 11", {bus.ack_toggle, bus.busy});
        end
        nios_write(TAG_STATUS, 20'h00000);
        step(1);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.result_valid);
        end
        step(1);
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b expected 1", bus.result_valid);
        end
        checks++;
        if ({bus.result, bus.result_mag} !== {20'd100, 20'd100}) begin
            errors++; $display("FAIL basic_result: got %h/%h expected 00064/00064", bus.result, bus.result_mag);
        end
        checks++;
        if ({bus.neg_out, bus.div_zero, bus.overflow, bus.timeout, bus.ack_toggle, bus.busy} !== 6'b000000) begin
            errors++;
            $display("FAIL basic_flags: got neg/dz/ov/to/ack/busy=%b expected 000000",
                     {bus.neg_out, bus.div_zero, bus.overflow, bus.timeout, bus.ack_toggle, bus.busy});
        end
        step(1);
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b0, 20'd100}) begin
            errors++; $display("FAIL basic_hold: got valid=%b result=%h expected 0/00064", bus.result_valid, bus.result);
        end
    endtask

    task automatic test_negative();
        run_frame(20'hFFFF9, 20'h00000);
        checks++;
        if ({bus.result_valid, bus.result, bus.result_mag, bus.neg_out} !== {1'b1, 20'hFFFF9, 20'h00007, 1'b1}) begin
            errors++;
            $display("FAIL neg_small: got valid=%b result=%h mag=%h neg=%b expected 1/FFFF9/00007/1",
                     bus.result_valid, bus.result, bus.result_mag, bus.neg_out);
        end
        run_frame(20'h80000, 20'h00000);
        checks++;
        if ({bus.result_valid, bus.result_mag, bus.neg_out} !== {1'b1, 20'h80000, 1'b1}) begin
            errors++;
            $display("FAIL neg_min: got valid=%b mag=%h neg=%b expected 1/80000/1",
                     bus.result_valid, bus.result_mag, bus.neg_out);
        end
    endtask

    task automatic test_flags();
        run_frame(20'h00123, 20'h00001);
        checks++;
        if ({bus.result_valid, bus.result, bus.div_zero, bus.overflow} !== {1'b1, 20'h00123, 2'b10}) begin
            errors++;
            $display("FAIL div_zero: got valid=%b result=%h dz/ov=%b%b expected 1/00123/10",
                     bus.result_valid, bus.result, bus.div_zero, bus.overflow);
        end
        run_frame(20'h00456, 20'h00002);
        checks++;
        if ({bus.result, bus.div_zero, bus.overflow} !== {20'h00456, 2'b01}) begin
            errors++;
            $display("FAIL overflow: got result=%h dz/ov=%b%b expected 00456/01",
                     bus.result, bus.div_zero, bus.overflow);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        pulse_req();
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            step(1);
        end
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL timeout_cycles: got %0d busy cycles expected 16", n);
        end
        checks++;
        if ({bus.timeout, bus.result_valid} !== 2'b11) begin
            errors++; $display("FAIL timeout_flag: got to/valid=%b expected 11", {bus.timeout, bus.result_valid});
        end
        checks++;
        if ({bus.result, bus.overflow} !== {20'h00456, 1'b1}) begin
            errors++; $display("FAIL timeout_hold: got result=%h ov=%b expected 00456/1", bus.result, bus.overflow);
        end
        step(1);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_len: got %b expected 0", bus.result_valid);
        end
    endtask

    task automatic test_req_with_pending();
        nios_write(TAG_RESULT, 20'hFFFC2);
        step(1);
        bus.req = 1'b1;
        step(1);
        bus.req = 1'b0;
        checks++;
        if ({bus.ack_toggle, bus.busy} !== {~tog, 1'b1}) begin
            errors++; $display("FAIL req_pending_noack: got ack/busy=%b expected %b1", {bus.ack_toggle, bus.busy}, ~tog);
        end
        step(1);
        checks++;
        if ({bus.ack_toggle, bus.busy} !== {tog, 1'b1}) begin
            errors++; $display("FAIL req_pending_ack: got ack/busy=%b expected %b1", {bus.ack_toggle, bus.busy}, tog);
        end
        nios_write(TAG_STATUS, 20'h00003);
        step(2);
        checks++;
        if ({bus.result_valid, bus.result, bus.result_mag, bus.neg_out, bus.div_zero, bus.overflow, bus.timeout}
            !== {1'b1, 20'hFFFC2, 20'h0003E, 4'b1110}) begin
            errors++;
            $display("FAIL req_pending_frame: got valid=%b result=%h mag=%h neg/dz/ov/to=%b expected 1/FFFC2/0003E/1110",
                     bus.result_valid, bus.result, bus.result_mag,
                     {bus.neg_out, bus.div_zero, bus.overflow, bus.timeout});
        end
    endtask

    task automatic test_status_first();
        pulse_req();
        nios_write(TAG_STATUS, 20'h00000);
        step(2);
        checks++;
        if ({bus.result_valid, bus.div_zero, bus.overflow, bus.timeout, bus.busy, bus.result}
            !== {5'b11100, 20'hFFFC2}) begin
            errors++;
            $display("FAIL status_first: got valid/dz/ov/to/busy=%b result=%h expected 11100/FFFC2",
                     {bus.result_valid, bus.div_zero, bus.overflow, bus.timeout, bus.busy}, bus.result);
        end
    endtask

    task automatic test_clr();
        int p0;
        pulse_req();
        nios_write(TAG_RESULT, 20'h00055);
        step(2);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL clr_pre_busy: got %b expected 1", bus.busy);
        end
        p0 = pulse_cnt;
        nios_write(TAG_STATUS, 20'h00000);
        step(1);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        checks++;
        if ({bus.busy, bus.result, bus.result_mag, bus.neg_out, bus.div_zero, bus.overflow, bus.timeout,
             bus.result_valid} !== 46'h0) begin
            errors++;
            $display("FAIL clr_outputs: got busy=%b result=%h mag=%h flags=%b expected all zero", bus.busy,
                     bus.result, bus.result_mag, {bus.neg_out, bus.div_zero, bus.overflow, bus.timeout, bus.result_valid});
        end
        checks++;
        if (bus.ack_toggle !== tog) begin
            errors++; $display("FAIL clr_ack: got %b expected %b", bus.ack_toggle, tog);
        end
        step(2);
        checks++;
        if (pulse_cnt !== p0) begin
            errors++; $display("FAIL clr_no_pulse: got %0d pulses expected %0d", pulse_cnt, p0);
        end
    endtask

    task automatic test_clear_tag();
        int p0;
        p0 = pulse_cnt;
        pulse_req();
        nios_write(TAG_CLEAR, 20'h00000);
        step(2);
        checks++;
        if ({bus.busy, bus.ack_toggle} !== {1'b0, tog}) begin
            errors++; $display("FAIL clear_tag: got busy/ack=%b expected 0%b", {bus.busy, bus.ack_toggle}, tog);
        end
        pulse_req();
        nios_write(3'b100, 20'h00000);
        step(2);
        checks++;
        if ({bus.busy, bus.ack_toggle} !== {1'b0, tog}) begin
            errors++; $display("FAIL illegal_tag: got busy/ack=%b expected 0%b", {bus.busy, bus.ack_toggle}, tog);
        end
        step(1);
        checks++;
        if (pulse_cnt !== p0) begin
            errors++; $display("FAIL abort_tag_no_pulse: got %0d pulses expected %0d", pulse_cnt, p0);
        end
    endtask

    task automatic test_async_reset();
        run_frame(20'h00077, 20'h00002);
        pulse_req();
        checks++;
        if ({bus.busy, bus.result, bus.overflow} !== {1'b1, 20'h00077, 1'b1}) begin
            errors++; $display("FAIL areset_pre: got busy=%b result=%h ov=%b expected 1/00077/1",
                               bus.busy, bus.result, bus.overflow);
        end
        #5 reset = 1'b0;
        #1;
        checks++;
        if ({bus.ack_toggle, bus.busy, bus.result, bus.result_mag, bus.neg_out, bus.div_zero,
             bus.overflow, bus.timeout, bus.result_valid} !== 47'h0) begin
            errors++; $display("FAIL areset_outputs: got busy=%b result=%h ov=%b ack=%b expected all zero",
                               bus.busy, bus.result, bus.overflow, bus.ack_toggle);
        end
        tog = 1'b0;
        bus.pio_word = 24'h000000;
        step(1);
        reset = 1'b1;
        step(1);
        run_frame(20'h00010, 20'h00000);
        checks++;
        if ({bus.result_valid, bus.result, bus.ack_toggle} !== {1'b1, 20'h00010, 1'b0}) begin
            errors++; $display("FAIL areset_recover: got valid=%b result=%h ack=%b expected 1/00010/0",
                               bus.result_valid, bus.result, bus.ack_toggle);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_flags();
        test_timeout();
        test_req_with_pending();
        test_status_first();
        test_clr();
        test_clear_tag();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
